gcd_unit: RTL and testbench

Iterative greatest-common-divisor responder with latency-insensitive val/rdy request and response ports. It accepts one operand pair, runs Euclid's algorithm by repeated subtract and swap, and returns the result. It sits behind a test source or upstream requester and pairs with a response sink. Like the registered logic blocks in the same flow, it is written for clean synthesis with the OpenROAD tools.

---
 rtl/gcd_pkg.sv | 7 +
 rtl/gcd_dpath.sv | 39 +++
 rtl/gcd_unit.sv | 71 +++++++
 tb/tb_gcd_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// gcd_pkg: shared state/control encodings and default width for the GCD unit
package gcd_pkg;
  localparam int NBITS_DEFAULT = 16;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  typedef enum logic [1:0] {A_LOAD, A_SUB, A_SWAP, A_HOLD} a_sel_e;
  typedef enum logic [1:0] {B_LOAD, B_SWAP, B_HOLD} b_sel_e;
endpackage

// File: rtl/gcd_dpath.sv
// gcd_dpath: operand registers, subtractor and status flags for Euclid's algorithm
module gcd_dpath
  import gcd_pkg::*;
#(
  parameter int NBITS = NBITS_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  a_sel_e           a_sel,
  input  b_sel_e           b_sel,
  input  logic [NBITS-1:0] req_a,
  input  logic [NBITS-1:0] req_b,
  output logic             is_a_lt_b,
  output logic             is_b_zero,
  output logic [NBITS-1:0] a_o
);
  logic [NBITS-1:0] a_q, a_d, b_q, b_d, diff;
  // subtract is only selected when a_q >= b_q, so no underflow
  always_comb begin
    diff = a_q - b_q;
    a_d  = (a_sel == A_LOAD) ? req_a :
           (a_sel == A_SUB)  ? diff  :
           (a_sel == A_SWAP) ? b_q   : a_q;
    b_d  = (b_sel == B_LOAD) ? req_b :
           (b_sel == B_SWAP) ? a_q   : b_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end
  assign is_a_lt_b = a_q < b_q;
  assign is_b_zero = b_q == '0;
  assign a_o       = a_q;
endmodule

// File: rtl/gcd_unit.sv
// gcd_unit: val/rdy GCD responder; FSM control around gcd_dpath
module gcd_unit
  import gcd_pkg::*;
#(
  parameter int NBITS = NBITS_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_val,
  output logic             req_rdy,
  input  logic [NBITS-1:0] req_a,
  input  logic [NBITS-1:0] req_b,
  output logic             resp_val,
  input  logic             resp_rdy,
  output logic [NBITS-1:0] resp_data
);
  state_e state_q;
  logic   req_rdy_q, resp_val_q, is_a_lt_b, is_b_zero;
  a_sel_e a_sel;
  b_sel_e b_sel;
  always_comb begin
    a_sel = (state_q == IDLE && req_val) ? A_LOAD :
            (state_q != CALC) ? A_HOLD :
            is_a_lt_b         ? A_SWAP :
            !is_b_zero        ? A_SUB  : A_HOLD;
    b_sel = (state_q == IDLE && req_val)   ? B_LOAD :
            (state_q == CALC && is_a_lt_b) ? B_SWAP : B_HOLD;
  end
  // handshake outputs are registered alongside the state so no input reaches them
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      req_rdy_q  <= 1'b1;
      resp_val_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_val) begin
          state_q   <= CALC;
          req_rdy_q <= 1'b0;
        end
        CALC: if (!is_a_lt_b && is_b_zero) begin
          state_q    <= DONE;
          resp_val_q <= 1'b1;
        end
        DONE: if (resp_rdy) begin
          state_q    <= IDLE;
          resp_val_q <= 1'b0;
          req_rdy_q  <= 1'b1;
        end
        default: begin
          state_q    <= IDLE;
          req_rdy_q  <= 1'b1;
          resp_val_q <= 1'b0;
        end
      endcase
    end
  end
  gcd_dpath #(.NBITS(NBITS)) u_dpath (
    .clk       (clk),
    .reset     (reset),
    .a_sel     (a_sel),
    .b_sel     (b_sel),
    .req_a     (req_a),
    .req_b     (req_b),
    .is_a_lt_b (is_a_lt_b),
    .is_b_zero (is_b_zero),
    .a_o       (resp_data)
  );
  assign req_rdy  = req_rdy_q;
  assign resp_val = resp_val_q;
endmodule

// File: tb/tb_gcd_unit.sv
// tb_gcd_unit: directed and random scoreboard bench for gcd_unit
module tb_gcd_unit;
  localparam int NB = 16;
  localparam int NPAIRS = 202;
  logic clk = 1'b0, reset = 1'b0, req_val = 1'b0, resp_rdy = 1'b0;
  logic [NB-1:0] req_a = '0, req_b = '0;
  logic req_rdy, resp_val;
  logic [NB-1:0] resp_data;
  int cyc = 0, e0 = 0, n_chk = 0, n_pass = 0;
  logic [NB-1:0] q_exp[$];

  gcd_unit #(.NBITS(NB)) dut (
    .clk(clk), .reset(reset), .req_val(req_val), .req_rdy(req_rdy),
    .req_a(req_a), .req_b(req_b), .resp_val(resp_val), .resp_rdy(resp_rdy),
    .resp_data(resp_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [NB-1:0] gcd_ref(input int unsigned a, input int unsigned b);
    int unsigned t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a[NB-1:0];
  endfunction

  function automatic int unsigned quot_sum(input int unsigned a, input int unsigned b);
    int unsigned s = 0, t;
    if (a < b) begin t = a; a = b; b = t; end
    while (b != 0) begin
      s += a / b;
      t = a % b;
      a = b;
      b = t;
    end
    return s;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [NB-1:0] a, input logic [NB-1:0] b, output bit ok);
    bit rdy;
    ok = 0;
    req_a = a;
    req_b = b;
    req_val = 1'b1;
    for (int i = 0; i < 1000 && !ok; i++) begin
      rdy = req_rdy;
      tick();
      if (rdy) begin
        ok = 1;
        e0 = cyc;
        q_exp.push_back(gcd_ref(a, b));
      end
    end
    req_val = 1'b0;
  endtask

  task automatic wait_resp(input int max, output bit got);
    got = 0;
    for (int i = 0; i < max && !got; i++) begin
      if (resp_val) got = 1;
      else tick();
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if ({req_rdy, resp_val, resp_data} !== {2'b10, {NB{1'b0}}})
        $display("FAIL reset_hold cyc%0d: rdy/val/data=%b/%b/%0d want 1/0/0", i, req_rdy, resp_val, resp_data);
      else n_pass++;
    end
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_chk++;
      if ({req_rdy, resp_val, resp_data} !== {2'b10, {NB{1'b0}}})
        $display("FAIL reset_release cyc%0d: rdy/val/data=%b/%b/%0d want 1/0/0", i, req_rdy, resp_val, resp_data);
      else n_pass++;
    end
  endtask

  task automatic test_nominal;
    bit ok, got;
    logic [NB-1:0] exp;
    send(16'd15, 16'd5, ok);
    n_chk++;
    if (!ok) $display("FAIL nominal_accept: not accepted");
    else n_pass++;
    wait_resp(100, got);
    n_chk++;
    if (!got || cyc - e0 != 5) $display("FAIL nominal_latency: got=%0d edges=%0d want edges=5", got, cyc - e0);
    else n_pass++;
    exp = q_exp.pop_front();
    n_chk++;
    if (resp_data !== exp || exp !== 16'd5) $display("FAIL nominal_data: %0d want %0d", resp_data, exp);
    else n_pass++;
    resp_rdy = 1'b1;
    tick();
    resp_rdy = 1'b0;
    n_chk++;
    if ({req_rdy, resp_val} !== 2'b10) $display("FAIL nominal_return: rdy/val=%b/%b want 1/0", req_rdy, resp_val);
    else n_pass++;
  endtask

  task automatic test_special;
    logic [NB-1:0] ta[4] = '{16'd7, 16'd0, 16'd0, 16'd27};
    logic [NB-1:0] tb[4] = '{16'd0, 16'd9, 16'd0, 16'd15};
    int tl[4] = '{1, 2, 1, -1};
    bit ok, got;
    logic [NB-1:0] exp;
    for (int i = 0; i < 4; i++) begin
      send(ta[i], tb[i], ok);
      wait_resp(200, got);
      n_chk++;
      if (!ok || !got || (tl[i] >= 0 && cyc - e0 != tl[i]))
        $display("FAIL special_latency(%0d,%0d): ok=%0d got=%0d edges=%0d want %0d", ta[i], tb[i], ok, got, cyc - e0, tl[i]);
      else n_pass++;
      exp = q_exp.pop_front();
      n_chk++;
      if (resp_data !== exp) $display("FAIL special_data(%0d,%0d): %0d want %0d", ta[i], tb[i], resp_data, exp);
      else n_pass++;
      resp_rdy = 1'b1;
      tick();
      resp_rdy = 1'b0;
    end
  endtask

  task automatic test_backpressure;
    bit ok, got, bad = 0;
    logic [NB-1:0] exp;
    send(16'd12, 16'd8, ok);
    wait_resp(200, got);
    n_chk++;
    if (!ok || !got) $display("FAIL bp_response: ok=%0d got=%0d want 1/1", ok, got);
    else n_pass++;
    exp = q_exp.pop_front();
    for (int i = 0; i < 10; i++) begin
      req_val = i[0];
      req_a = 16'd99;
      req_b = 16'd33;
      if ({req_rdy, resp_val} !== 2'b01 || resp_data !== exp) bad = 1;
      tick();
    end
    req_val = 1'b0;
    n_chk++;
    if (bad || {req_rdy, resp_val} !== 2'b01 || resp_data !== exp)
      $display("FAIL bp_hold: rdy/val/data=%b/%b/%0d want 0/1/%0d", req_rdy, resp_val, resp_data, exp);
    else n_pass++;
    resp_rdy = 1'b1;
    tick();
    resp_rdy = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if ({req_rdy, resp_val} !== 2'b10) bad = 1;
      tick();
    end
    n_chk++;
    if (bad) $display("FAIL bp_single_transfer: rdy/val=%b/%b want 1/0", req_rdy, resp_val);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [NB-1:0] pa[NPAIRS], pb[NPAIRS];
    int got = 0;
    pa[0] = 16'd49;  pb[0] = 16'd21;
    pa[1] = 16'd100; pb[1] = 16'd75;
    for (int i = 2; i < NPAIRS; i++) begin
      do begin
        pa[i] = NB'($urandom_range(0, 65535));
        pb[i] = NB'($urandom_range(0, 65535));
      end while (quot_sum(pa[i], pb[i]) > 300);
    end
    fork
      begin
        int k = 0;
        bit rdy;
        for (int g = 0; g < 60000 && k < NPAIRS; g++) begin
          req_val = ($urandom_range(0, 3) != 0);
          req_a = pa[k];
          req_b = pb[k];
          rdy = req_rdy;
          tick();
          if (req_val && rdy) begin
            q_exp.push_back(gcd_ref(pa[k], pb[k]));
            k++;
          end
        end
        req_val = 1'b0;
      end
      begin
        bit v;
        logic [NB-1:0] d, e;
        for (int g = 0; g < 60000 && got < NPAIRS; g++) begin
          resp_rdy = $urandom_range(0, 1) != 0;
          v = resp_val;
          d = resp_data;
          tick();
          if (v && resp_rdy) begin
            n_chk++;
            if (q_exp.size() == 0) $display("FAIL stream_extra: response %0d=%0d with empty scoreboard", got, d);
            else begin
              e = q_exp.pop_front();
              if (d !== e) $display("FAIL stream_data #%0d: %0d want %0d", got, d, e);
              else n_pass++;
            end
            got++;
          end
        end
        resp_rdy = 1'b0;
      end
    join
    n_chk++;
    if (got != NPAIRS || q_exp.size() != 0)
      $display("FAIL stream_count: received %0d pending %0d want %0d/0", got, q_exp.size(), NPAIRS);
    else n_pass++;
  endtask

  task automatic test_reset_mid_calc;
    bit ok, got, bad = 0;
    logic [NB-1:0] exp;
    send(16'hFFFF, 16'd1, ok);
    repeat (20) tick();
    reset = 1'b0;
    #1;
    n_chk++;
    if ({req_rdy, resp_val, resp_data} !== {2'b10, {NB{1'b0}}})
      $display("FAIL midcalc_reset: rdy/val/data=%b/%b/%0d want 1/0/0", req_rdy, resp_val, resp_data);
    else n_pass++;
    q_exp.delete();
    repeat (2) tick();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (resp_val !== 1'b0 || req_rdy !== 1'b1) bad = 1;
    end
    n_chk++;
    if (bad) $display("FAIL midcalc_no_resp: rdy/val=%b/%b want 1/0", req_rdy, resp_val);
    else n_pass++;
    send(16'd6, 16'd4, ok);
    wait_resp(200, got);
    exp = q_exp.pop_front();
    n_chk++;
    if (!ok || !got || resp_data !== exp) $display("FAIL midcalc_next: ok=%0d got=%0d data=%0d want %0d", ok, got, resp_data, exp);
    else n_pass++;
    resp_rdy = 1'b1;
    tick();
    resp_rdy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_special();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_calc();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
